biriscv_issue_scheduler: RTL

- Dual-issue scheduler between the two instruction decoders and the execute stage.
- Takes per-slot unit classification (exec/lsu/branch/mul/div/csr, rd_valid) plus register indices, and decides each cycle which slots issue.
- Enforces in-order issue, structural pairing rules and short-latency RAW/WAW hazards.
- Sequences the multi-cycle divider with a busy counter and a single-entry destination scoreboard.

---
 rtl/biriscv_issue_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/biriscv_issue_scheduler.sv
// -----------------------------------------------------------------------------
// biriscv_issue_scheduler
//
// Dual-issue scheduler sitting between the two instruction decoders and the
// execute stage. Each cycle it decides which of the two decoded slots issue.
// Slot0 is always the older instruction, so slot1 can only issue alongside it.
//
// Issue is blocked by:
//   - short-latency RAW/WAW hazards against a load or mul issued last cycle;
//   - an outstanding divide, both for its destination and for the divider
//     itself;
//   - pairing rules that stop two instructions from sharing a unit or
//     depending on each other.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   stall_i, flush_i        suppress issue this cycle
//   slotN_*_i (N=0,1)       decoded instruction: valid, unit class, rd_valid,
//                           rd/ra/rb register indices
//   slotN_accept_o          combinational: slot N issues this cycle
//   exN_*_o                 registered: slot N issued last cycle, plus unit class
//   div_busy_o              divider still running
//   div_rd_o                destination register of the outstanding divide
// -----------------------------------------------------------------------------
module biriscv_issue_scheduler #(
    parameter int SUPPORT_DUAL_ISSUE = 1,
    parameter int DIV_CYCLES         = 34
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stall_i,
    input  logic       flush_i,

    input  logic       slot0_valid_i,
    input  logic       slot0_exec_i,
    input  logic       slot0_lsu_i,
    input  logic       slot0_branch_i,
    input  logic       slot0_mul_i,
    input  logic       slot0_div_i,
    input  logic       slot0_csr_i,
    input  logic       slot0_rd_valid_i,
    input  logic [4:0] slot0_rd_idx_i,
    input  logic [4:0] slot0_ra_idx_i,
    input  logic [4:0] slot0_rb_idx_i,
    output logic       slot0_accept_o,

    input  logic       slot1_valid_i,
    input  logic       slot1_exec_i,
    input  logic       slot1_lsu_i,
    input  logic       slot1_branch_i,
    input  logic       slot1_mul_i,
    input  logic       slot1_div_i,
    input  logic       slot1_csr_i,
    input  logic       slot1_rd_valid_i,
    input  logic [4:0] slot1_rd_idx_i,
    input  logic [4:0] slot1_ra_idx_i,
    input  logic [4:0] slot1_rb_idx_i,
    output logic       slot1_accept_o,

    output logic       ex0_valid_o,
    output logic       ex0_lsu_o,
    output logic       ex0_mul_o,
    output logic       ex0_div_o,
    output logic       ex0_csr_o,

    output logic       ex1_valid_o,
    output logic       ex1_lsu_o,
    output logic       ex1_mul_o,
    output logic       ex1_div_o,
    output logic       ex1_csr_o,

    output logic       div_busy_o,
    output logic [4:0] div_rd_o
);

    localparam logic       DUAL_EN   = (SUPPORT_DUAL_ISSUE != 0);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

    // Per-slot views of the decoder inputs so both slots share one check.
    logic [1:0] w_valid;
    logic [1:0] w_lsu;
    logic [1:0] w_mul;
    logic [1:0] w_div;
    logic [1:0] w_csr;
    logic [1:0] w_rd_valid;
    logic [4:0] w_rd [2];
    logic [4:0] w_ra [2];
    logic [4:0] w_rb [2];
    logic [1:0] w_block;
    logic [1:0] w_accept;

    // State
    logic [4:0] r_load_rd;
    logic [4:0] r_mul_rd;
    logic [4:0] r_div_rd;
    logic [5:0] r_div_cnt;
    logic [1:0] r_ex_valid;
    logic [1:0] r_ex_lsu;
    logic [1:0] r_ex_mul;
    logic [1:0] r_ex_div;
    logic [1:0] r_ex_csr;

    logic       w_div_busy;
    logic       w_pair_ok;
    logic       w_unused;

    assign w_valid    = {slot1_valid_i,    slot0_valid_i};
    assign w_lsu      = {slot1_lsu_i,      slot0_lsu_i};
    assign w_mul      = {slot1_mul_i,      slot0_mul_i};
    assign w_div      = {slot1_div_i,      slot0_div_i};
    assign w_csr      = {slot1_csr_i,      slot0_csr_i};
    assign w_rd_valid = {slot1_rd_valid_i, slot0_rd_valid_i};
    assign w_rd[0] = slot0_rd_idx_i;
    assign w_rd[1] = slot1_rd_idx_i;
    assign w_ra[0] = slot0_ra_idx_i;
    assign w_ra[1] = slot1_ra_idx_i;
    assign w_rb[0] = slot0_rb_idx_i;
    assign w_rb[1] = slot1_rb_idx_i;

    // exec class and slot1 branch do not influence scheduling.
    assign w_unused = slot0_exec_i ^ slot1_exec_i ^ slot1_branch_i;

    assign w_div_busy = (r_div_cnt != 6'd0);

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic f_depends(input logic [4:0] x,
                                       input logic [4:0] ra,
                                       input logic [4:0] rb,
                                       input logic [4:0] rd,
                                       input logic       rd_v);
        return (x != 5'd0) && ((x == ra) || (x == rb) || (rd_v && (x == rd)));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot_block
            assign w_block[gi] =
                  f_depends(r_load_rd, w_ra[gi], w_rb[gi], w_rd[gi], w_rd_valid[gi])
                | f_depends(r_mul_rd,  w_ra[gi], w_rb[gi], w_rd[gi], w_rd_valid[gi])
                | (w_div_busy & f_depends(r_div_rd, w_ra[gi], w_rb[gi], w_rd[gi], w_rd_valid[gi]))
                | (w_div_busy & (w_div[gi] | w_csr[gi]))
                // CSR/system ops wait for any short-latency result to land.
                | (w_csr[gi] & ((r_load_rd != 5'd0) | (r_mul_rd != 5'd0)));
        end
    endgenerate

    // Rules that only apply when pairing slot1 with slot0.
    assign w_pair_ok = ~slot1_csr_i & ~slot1_div_i
                     & ~slot0_csr_i & ~slot0_branch_i
                     & ~(slot0_lsu_i & slot1_lsu_i)
                     & ~(slot0_mul_i & slot1_mul_i)
                     & ~(slot0_rd_valid_i && (slot0_rd_idx_i != 5'd0) &&
                         ((slot0_rd_idx_i == slot1_ra_idx_i) ||
                          (slot0_rd_idx_i == slot1_rb_idx_i)))
                     & ~(slot0_rd_valid_i && slot1_rd_valid_i &&
                         (slot0_rd_idx_i != 5'd0) &&
                         (slot0_rd_idx_i == slot1_rd_idx_i));

    assign w_accept[0] = w_valid[0] & ~stall_i & ~flush_i & ~rst_i & ~w_block[0];
    assign w_accept[1] = DUAL_EN & w_accept[0] & w_valid[1] & ~w_block[1] & w_pair_ok;

    assign slot0_accept_o = w_accept[0];
    assign slot1_accept_o = w_accept[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_load_rd  <= 5'd0;
            r_mul_rd   <= 5'd0;
            r_div_rd   <= 5'd0;
            r_div_cnt  <= 6'd0;
            r_ex_valid <= 2'b00;
            r_ex_lsu   <= 2'b00;
            r_ex_mul   <= 2'b00;
            r_ex_div   <= 2'b00;
            r_ex_csr   <= 2'b00;
        end else begin
            // Issue register refreshes every cycle, so a stall yields a bubble.
            r_ex_valid <= w_accept;
            r_ex_lsu   <= w_accept & w_lsu;
            r_ex_mul   <= w_accept & w_mul;
            r_ex_div   <= w_accept & w_div;
            r_ex_csr   <= w_accept & w_csr;

            // At most one load and one mul can issue per cycle (pairing rules).
            if (w_accept[0] && w_lsu[0] && w_rd_valid[0]) begin
                r_load_rd <= w_rd[0];
            end else if (w_accept[1] && w_lsu[1] && w_rd_valid[1]) begin
                r_load_rd <= w_rd[1];
            end else begin
                r_load_rd <= 5'd0;
            end

            if (w_accept[0] && w_mul[0] && w_rd_valid[0]) begin
                r_mul_rd <= w_rd[0];
            end else if (w_accept[1] && w_mul[1] && w_rd_valid[1]) begin
                r_mul_rd <= w_rd[1];
            end else begin
                r_mul_rd <= 5'd0;
            end

            // Divider ignores stall/flush: the in-flight div is older than both.
            if (w_accept[0] && w_div[0]) begin
                r_div_cnt <= DIV_LOAD;
                r_div_rd  <= w_rd[0];
            end else if (w_div_busy) begin
                r_div_cnt <= r_div_cnt - 6'd1;
            end
        end
    end

    assign ex0_valid_o = r_ex_valid[0];
    assign ex0_lsu_o   = r_ex_lsu[0];
    assign ex0_mul_o   = r_ex_mul[0];
    assign ex0_div_o   = r_ex_div[0];
    assign ex0_csr_o   = r_ex_csr[0];
    assign ex1_valid_o = r_ex_valid[1];
    assign ex1_lsu_o   = r_ex_lsu[1];
    assign ex1_mul_o   = r_ex_mul[1];
    assign ex1_div_o   = r_ex_div[1];
    assign ex1_csr_o   = r_ex_csr[1];

    assign div_busy_o = w_div_busy;
    assign div_rd_o   = r_div_rd;

endmodule
